decode_issue_stage: RTL and testbench

- Decode/issue stage directly upstream of the register file's consumers.
- Accepts 32-bit instructions from fetch and drives the register file's two read addresses.
- Tracks in-flight destination writes in a 16-entry scoreboard and stalls on RAW/WAW hazards.
- Captures decoded operands into the ID/EX pipeline register using a valid/ready handshake. The writeback port also feeds this block so that scoreboard entries are retired.

---
 rtl/decode_issue_stage_if.sv | 45 ++++
 rtl/decode_issue_stage.sv | 132 +++++++++++++
 tb/tb_decode_issue_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_stage_if.sv
// Bundle of every non-clock signal between decode/issue and its neighbours:
// the fetch handshake, the register-file read ports, writeback, flush and
// the ID/EX handshake. The environment drives through 'master'. The stage
// itself connects through 'slave'.
interface decode_issue_stage_if #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
);
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic               id_ready;
    logic [3:0]         reg1_read_address;
    logic [3:0]         reg2_read_address;
    logic [DATA_W-1:0]  reg1_data;
    logic [DATA_W-1:0]  reg2_data;
    logic               wb_is_write;
    logic [3:0]         wb_address;
    logic [DATA_W-1:0]  wb_data;
    logic               flush;
    logic               ex_valid;
    logic               ex_ready;
    logic [3:0]         ex_opcode;
    logic [3:0]         ex_rd;
    logic               ex_writes;
    logic [DATA_W-1:0]  ex_op1;
    logic [DATA_W-1:0]  ex_op2;
    logic [DATA_W-1:0]  ex_imm;
    logic [15:0]        busy_mask;

    modport master (
        output id_valid, id_instr, reg1_data, reg2_data,
               wb_is_write, wb_address, wb_data, flush, ex_ready,
        input  id_ready, reg1_read_address, reg2_read_address,
               ex_valid, ex_opcode, ex_rd, ex_writes, ex_op1, ex_op2, ex_imm,
               busy_mask
    );

    modport slave (
        input  id_valid, id_instr, reg1_data, reg2_data,
               wb_is_write, wb_address, wb_data, flush, ex_ready,
        output id_ready, reg1_read_address, reg2_read_address,
               ex_valid, ex_opcode, ex_rd, ex_writes, ex_op1, ex_op2, ex_imm,
               busy_mask
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage.
// - Decodes a 32-bit instruction and drives the two register-file read
//   addresses.
// - Keeps a 16-entry busy scoreboard of in-flight destination writes.
//   It stalls on RAW hazards (rs1/rs2) and on WAW hazards (rd).
// - Loads the ID/EX register over a valid/ready handshake.
// - Writeback retires scoreboard entries. Flush squashes the decode slot
//   and the ID/EX register.
// Optional build macro DECODE_WB_BYPASS_EN:
// - A writeback to a source register in the same cycle removes that hazard.
// - That operand is then forwarded from wb_data.
// - A writeback to rd likewise masks the WAW check.
module decode_issue_stage #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    decode_issue_stage_if.slave bus
);
    typedef struct packed {
        logic [3:0]        opcode;
        logic [3:0]        rd;
        logic              writes;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] imm;
    } idex_t;

    idex_t       idex_q, idex_d;
    logic        ex_valid_q, ex_valid_d;
    logic [15:0] busy_q, busy_d;

    // Instruction fields (fixed map for a 32-bit instruction word).
    logic [3:0]  opcode, rd, rs1, rs2;
    logic [15:0] imm;
    logic        writes;

    assign opcode = bus.id_instr[INSTR_W-1 -: 4];
    assign rd     = bus.id_instr[27:24];
    assign rs1    = bus.id_instr[23:20];
    assign rs2    = bus.id_instr[19:16];
    assign imm    = bus.id_instr[15:0];
    assign writes = ~opcode[3];

    // Per-operand bypass qualifiers. They are tied low when forwarding is
    // not built in, so the operand muxes below reduce to the register file.
    logic byp1, byp2, bypd;
`ifdef DECODE_WB_BYPASS_EN
    assign byp1 = bus.wb_is_write && (bus.wb_address == rs1);
    assign byp2 = bus.wb_is_write && (bus.wb_address == rs2);
    assign bypd = bus.wb_is_write && (bus.wb_address == rd);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign bypd = 1'b0;
`endif

    logic [DATA_W-1:0] op1, op2;
    logic              hazard, slot_free, issue;

    assign op1 = byp1 ? bus.wb_data : bus.reg1_data;
    assign op2 = byp2 ? bus.wb_data : bus.reg2_data;

    assign hazard    = (busy_q[rs1] & ~byp1) | (busy_q[rs2] & ~byp2)
                     | (writes & busy_q[rd] & ~bypd);
    assign slot_free = ~ex_valid_q | bus.ex_ready;
    assign issue     = bus.id_valid & ~hazard & slot_free & ~bus.flush;

    // Under flush the fetch word is consumed and dropped.
    // While reset is asserted nothing is accepted.
    assign bus.id_ready          = rst_n & (issue | bus.flush);
    assign bus.reg1_read_address = rs1;
    assign bus.reg2_read_address = rs2;

    // Next-state for the ID/EX register and the busy scoreboard.
    always_comb begin
        // NOTE: every variable gets a default first; otherwise a path that skips it infers a latch.
        idex_d     = idex_q;
        ex_valid_d = ex_valid_q;
        busy_d     = busy_q;

        if (bus.flush) begin
            ex_valid_d = 1'b0;
            // A squashed writer that execute never took will never write back.
            if (ex_valid_q && idex_q.writes && !bus.ex_ready) begin
                busy_d[idex_q.rd] = 1'b0;
            end
        end else if (issue) begin
            ex_valid_d    = 1'b1;
            idex_d.opcode = opcode;
            idex_d.rd     = rd;
            idex_d.writes = writes;
            idex_d.op1    = op1;
            idex_d.op2    = op2;
            idex_d.imm    = {{(DATA_W-16){imm[15]}}, imm};
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end

        // The clear is applied before the set, so a set on the same index wins.
        if (bus.wb_is_write) begin
            busy_d[bus.wb_address] = 1'b0;
        end
        if (issue && writes) begin
            busy_d[rd] = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            idex_q     <= '0;
            busy_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            idex_q     <= idex_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_opcode = idex_q.opcode;
    assign bus.ex_rd     = idex_q.rd;
    assign bus.ex_writes = idex_q.writes;
    assign bus.ex_op1    = idex_q.op1;
    assign bus.ex_op2    = idex_q.op2;
    assign bus.ex_imm    = idex_q.imm;
    assign bus.busy_mask = busy_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Testbench for decode_issue_stage.
// A reference model holds the set of registers with an in-flight writer,
// the register-file contents and the ID/EX occupancy. Each expected issue
// is pushed into a queue. A separate monitor pops and compares an entry
// whenever execute consumes the ID/EX register.
module tb_decode_issue_stage;
    localparam int DATA_W = 64;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic        writes;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] imm;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_issue_stage_if #(.DATA_W(DATA_W)) bus ();
    decode_issue_stage #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    txn_t exp_q[$];

    // Reference model state.
    logic [63:0] rf [16];
    bit          pend [16];
    bit          m_exv;
    bit          m_exw;
    logic [3:0]  m_exrd;
    bit          m_known = 1'b0;
    logic        got_ready;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    function automatic logic [15:0] pend_mask();
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) if (pend[i]) m |= 16'(1) << i;
        return m;
    endfunction

    // One clock cycle: drive the inputs, check the combinational outputs and
    // the current state, then advance the model across the clock edge.
    task automatic step(input bit v, input logic [31:0] instr, input bit wb,
                        input logic [3:0] wa, input logic [63:0] wd,
                        input bit fl, input bit rdy);
        logic [3:0] op, rd, rs1, rs2;
        bit         w, b1, b2, bd, hz, iss;
        txn_t       t;
        op  = instr[31:28];
        rd  = instr[27:24];
        rs1 = instr[23:20];
        rs2 = instr[19:16];
        bus.id_valid    = v;
        bus.id_instr    = instr;
        bus.reg1_data   = rf[rs1];
        bus.reg2_data   = rf[rs2];
        bus.wb_is_write = wb;
        bus.wb_address  = wa;
        bus.wb_data     = wd;
        bus.flush       = fl;
        bus.ex_ready    = rdy;
        #1;
        w   = !op[3];
        b1  = BYP && wb && (wa == rs1);
        b2  = BYP && wb && (wa == rs2);
        bd  = BYP && wb && (wa == rd);
        hz  = (pend[rs1] && !b1) || (pend[rs2] && !b2) || (w && pend[rd] && !bd);
        iss = rst_n && v && !hz && (!m_exv || rdy) && !fl;
        t.opcode = op;
        t.rd     = rd;
        t.writes = w;
        t.op1    = b1 ? wd : rf[rs1];
        t.op2    = b2 ? wd : rf[rs2];
        t.imm    = longint'($signed(instr[15:0]));

        got_ready = bus.id_ready;
        check("id_ready", 64'(bus.id_ready), 64'(rst_n && (iss || fl)));
        check("rd1_addr", 64'(bus.reg1_read_address), 64'(rs1));
        check("rd2_addr", 64'(bus.reg2_read_address), 64'(rs2));
        if (m_known) begin
            check("busy_mask", 64'(bus.busy_mask), 64'(pend_mask()));
            check("ex_valid", 64'(bus.ex_valid), 64'(m_exv));
        end

        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) pend[i] = 1'b0;
            m_exv   = 1'b0;
            m_known = 1'b1;
            exp_q.delete();
        end else begin
            if (fl) begin
                if (m_exv && !rdy) begin
                    if (m_exw) pend[m_exrd] = 1'b0;
                    exp_q.delete();
                end
                m_exv = 1'b0;
            end else if (!iss && rdy) begin
                m_exv = 1'b0;
            end
            if (wb) pend[wa] = 1'b0;
            if (iss) begin
                if (w) pend[rd] = 1'b1;
                m_exv  = 1'b1;
                m_exw  = w;
                m_exrd = rd;
                exp_q.push_back(t);
            end
        end
        if (wb) rf[wa] = wd;
        #1;
    endtask

    // Monitor: execute consumes ID/EX when ex_valid and ex_ready are both high.
    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ex got=consume exp=none @%0t", $time);
                end else begin
                    t = exp_q.pop_front();
                    check("ex_opcode", 64'(bus.ex_opcode), 64'(t.opcode));
                    check("ex_rd", 64'(bus.ex_rd), 64'(t.rd));
                    check("ex_writes", 64'(bus.ex_writes), 64'(t.writes));
                    check("ex_op1", bus.ex_op1, t.op1);
                    check("ex_op2", bus.ex_op2, t.op2);
                    check("ex_imm", bus.ex_imm, t.imm);
                end
            end
        end
    end

    function automatic logic [3:0] pick_reg();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
    endfunction

    initial begin : stimulus
        logic [31:0] c;
        logic [3:0]  wa;
        int          idx[$];

        bus.id_valid    = 1'b0;
        bus.id_instr    = '0;
        bus.reg1_data   = '0;
        bus.reg2_data   = '0;
        bus.wb_is_write = 1'b0;
        bus.wb_address  = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
        bus.ex_ready    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf[i]   = {$urandom, $urandom};
            pend[i] = 1'b0;
        end
        m_exv = 1'b0;

        // Reset held two cycles while fetch offers an instruction.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 16'h1), 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        check("reset_id_ready", 64'(got_ready), 64'd0);
        step(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 16'h1), 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        check("reset_id_ready2", 64'(got_ready), 64'd0);
        check("reset_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("reset_busy", 64'(bus.busy_mask), 64'd0);
        check("reset_ex_op1", bus.ex_op1, 64'd0);
        rst_n = 1'b1;

        // Back-to-back independent instructions.
        rf[2] = 64'hA; rf[3] = 64'hB; rf[5] = 64'hA; rf[6] = 64'hB;
        step(1'b1, mk(4'd0, 4'd1, 4'd2, 4'd3, 16'h0011), 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("b2b_ready0", 64'(got_ready), 64'd1);
        step(1'b1, mk(4'd0, 4'd4, 4'd5, 4'd6, 16'h0022), 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("b2b_ready1", 64'(got_ready), 64'd1);
        check("b2b_op1", bus.ex_op1, 64'hA);
        step(1'b0, 32'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("b2b_busy", 64'(bus.busy_mask), 64'h0012);

        // RAW stall on rs1 with writeback three cycles after the producer.
        step(1'b0, 32'd0, 1'b1, 4'd1, 64'h1111, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 4'd4, 64'h4444, 1'b0, 1'b1);
        step(1'b1, mk(4'd0, 4'd1, 4'd8, 4'd9, 16'h0), 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        c = mk(4'd0, 4'd10, 4'd1, 4'd9, 16'h5);
        step(1'b1, c, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("raw_stall0", 64'(got_ready), 64'd0);
        step(1'b1, c, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("raw_stall1", 64'(got_ready), 64'd0);
        step(1'b1, c, 1'b1, 4'd1, 64'h55, 1'b0, 1'b1);
        check("raw_wb_cycle", 64'(got_ready), 64'(BYP));
        if (!BYP) begin
            step(1'b1, c, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
            check("raw_after_wb", 64'(got_ready), 64'd1);
        end
        step(1'b0, 32'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("raw_op1", bus.ex_op1, 64'h55);
        step(1'b0, 32'd0, 1'b1, 4'd10, 64'hAAAA, 1'b0, 1'b1);

        // Backpressure: ID/EX held, fetch stalled for every held cycle.
        step(1'b1, mk(4'd0, 4'd11, 4'd12, 4'd13, 16'h7), 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(4'd1, 4'd12, 4'd13, 4'd14, 16'h9), 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
            check("bp_id_ready", 64'(got_ready), 64'd0);
            check("bp_ex_rd", 64'(bus.ex_rd), 64'd11);
            check("bp_ex_imm", bus.ex_imm, 64'h7);
        end
        step(1'b0, 32'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);

        // Flush while a writer to r7 is held in ID/EX.
        step(1'b1, mk(4'd0, 4'd7, 4'd0, 4'd0, 16'h0), 1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        step(1'b1, mk(4'd0, 4'd8, 4'd0, 4'd0, 16'h0), 1'b0, 4'd0, 64'd0, 1'b1, 1'b0);
        check("flush_id_ready", 64'(got_ready), 64'd1);
        check("flush_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("flush_busy7", 64'(bus.busy_mask[7]), 64'd0);
        check("flush_busy8", 64'(bus.busy_mask[8]), 64'd0);
        step(1'b0, 32'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);

        // Store (no write) to a busy rd: no WAW stall, imm sign-extended.
        step(1'b1, mk(4'd0, 4'd2, 4'd8, 4'd9, 16'h0), 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        step(1'b1, mk(4'd8, 4'd2, 4'd13, 4'd14, 16'h8000), 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("store_ready", 64'(got_ready), 64'd1);
        check("store_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_8000);
        check("store_writes", 64'(bus.ex_writes), 64'd0);
        step(1'b0, 32'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);

        // Randomized traffic with one reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            idx = {};
            for (int i = 0; i < 16; i++) if (pend[i]) idx.push_back(i);
            if (idx.size() > 0 && $urandom_range(0, 1) == 0)
                wa = 4'(idx[$urandom_range(0, idx.size() - 1)]);
            else
                wa = 4'($urandom);
            rst_n = (n != 1500);
            step($urandom_range(0, 9) < 8,
                 mk(4'($urandom), pick_reg(), pick_reg(), pick_reg(), 16'($urandom)),
                 $urandom_range(0, 2) == 0, wa, {$urandom, $urandom},
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
